// File: rtl/exposure_ctrl.sv
// Pixel-array frame sequencer: erase, expose, convert, row readout.
// Define EXPOSURE_ADJ_EN to allow exp_inc/exp_dec to trim exp_time.
module exposure_ctrl #(
  parameter int EXP_W       = 5,
  parameter int EXP_DEFAULT = 16,
  parameter int EXP_MIN     = 2,
  parameter int EXP_MAX     = 30,
  parameter int CONV_CYC    = 2,
  parameter int ROWS        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             exp_inc,
  input  logic             exp_dec,
  output logic             erase,
  output logic             expose,
  output logic             convert,
  output logic             read,
  output logic             shift_en,
  output logic             done,
  output logic [EXP_W-1:0] exp_time
);

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    EXPOSE,
    CONVERT,
    READ
  } state_t;

  state_t           state;
  logic [EXP_W-1:0] cnt;

  // cnt is loaded with phase length minus one on entry, so loading it
  // from exp_time is the exposure snapshot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      erase    <= 1'b0;
      expose   <= 1'b0;
      convert  <= 1'b0;
      read     <= 1'b0;
      shift_en <= 1'b0;
      done     <= 1'b0;
    end else begin
      erase    <= 1'b0;
      expose   <= 1'b0;
      convert  <= 1'b0;
      read     <= 1'b0;
      shift_en <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (init) begin
            state <= ERASE;
            erase <= 1'b1;
          end
        end
        ERASE: begin
          state  <= EXPOSE;
          cnt    <= exp_time - EXP_W'(1);
          expose <= 1'b1;
        end
        EXPOSE: begin
          if (cnt == '0) begin
            state   <= CONVERT;
            cnt     <= EXP_W'(CONV_CYC - 1);
            convert <= 1'b1;
          end else begin
            cnt    <= cnt - EXP_W'(1);
            expose <= 1'b1;
          end
        end
        CONVERT: begin
          if (cnt == '0) begin
            state    <= READ;
            cnt      <= EXP_W'(ROWS - 1);
            read     <= 1'b1;
            shift_en <= 1'b1;
          end else begin
            cnt     <= cnt - EXP_W'(1);
            convert <= 1'b1;
          end
        end
        READ: begin
          if (cnt == '0) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            cnt      <= cnt - EXP_W'(1);
            shift_en <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef EXPOSURE_ADJ_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_time <= EXP_W'(EXP_DEFAULT);
    end else if (exp_inc && !exp_dec) begin
      if (exp_time < EXP_W'(EXP_MAX))
        exp_time <= exp_time + EXP_W'(1);
    end else if (exp_dec && !exp_inc) begin
      if (exp_time > EXP_W'(EXP_MIN))
        exp_time <= exp_time - EXP_W'(1);
    end
  end
`else
  logic unused_adj;
  assign unused_adj = exp_inc ^ exp_dec;
  assign exp_time   = EXP_W'(EXP_DEFAULT);
`endif

endmodule
